triangle_setup: RTL

- Per-frame setup stage directly upstream of the flat-top and flat-bottom triangle rasterizers.
- Takes three arbitrary integer screen-space vertices and sorts them by y.
- Splits the triangle at the middle vertex into a flat-bottom half (apex up) and a flat-top half (apex down).
- Produces fixed-point vertex positions and per-scanline x increments for both halves, using one shared iterative signed divider. Results are held stable until the next job so the rasterizers can capture them on fsync.

---
 rtl/triangle_setup.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/triangle_setup.sv
// Triangle setup: sorts three vertices by y, splits at the middle vertex and
// produces fixed-point vertices and per-line x steps for both triangle halves.
module triangle_setup #(
    parameter int SLOPE_RES = 28,
    parameter int FRACT_RES = 16,
    parameter int COORD_RES = 12
) (
    input  logic                        pixel_clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic signed [COORD_RES-1:0] x_v0,
    input  logic signed [COORD_RES-1:0] y_v0,
    input  logic signed [COORD_RES-1:0] x_v1,
    input  logic signed [COORD_RES-1:0] y_v1,
    input  logic signed [COORD_RES-1:0] x_v2,
    input  logic signed [COORD_RES-1:0] y_v2,
    output logic                        busy,
    output logic                        done,
    output logic signed [SLOPE_RES-1:0] b_x_p1,
    output logic signed [SLOPE_RES-1:0] b_y_p1,
    output logic signed [SLOPE_RES-1:0] b_x_p2,
    output logic signed [SLOPE_RES-1:0] b_y_p2,
    output logic signed [SLOPE_RES-1:0] b_x_p3,
    output logic signed [SLOPE_RES-1:0] b_y_p3,
    output logic signed [SLOPE_RES-1:0] b_dx_p1p2,
    output logic signed [SLOPE_RES-1:0] b_dx_p1p3,
    output logic signed [SLOPE_RES-1:0] t_x_p1,
    output logic signed [SLOPE_RES-1:0] t_y_p1,
    output logic signed [SLOPE_RES-1:0] t_x_p2,
    output logic signed [SLOPE_RES-1:0] t_y_p2,
    output logic signed [SLOPE_RES-1:0] t_x_p3,
    output logic signed [SLOPE_RES-1:0] t_y_p3,
    output logic signed [SLOPE_RES-1:0] t_dx_p1p2,
    output logic signed [SLOPE_RES-1:0] t_dx_p1p3
);
    // state     | meaning
    // IDLE      | waiting for start, vertices captured on start
    // SORT      | order captured vertices into top/mid/bot (stable)
    // DIV_LONG  | slope top->bot
    // DIV_TM    | slope top->mid
    // DIV_MB    | slope mid->bot
    // SPLIT     | x of the long edge at y_mid
    // ORDER     | pick left/right base, register all outputs
    // DONE      | one-cycle completion pulse

    localparam int DIFF_RES = COORD_RES + 1;
    localparam int CNT_RES  = $clog2(SLOPE_RES + 1);
    localparam logic [CNT_RES-1:0] CNT_LOAD = CNT_RES'(SLOPE_RES);

    typedef enum logic [2:0] {
        IDLE, SORT, DIV_LONG, DIV_TM, DIV_MB, SPLIT, ORDER, DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [COORD_RES-1:0] vx [3];
    logic signed [COORD_RES-1:0] vy [3];
    logic [1:0]                  rank [3];
    logic signed [COORD_RES-1:0] x_top, y_top, x_mid, y_mid, x_bot, y_bot;

    logic [CNT_RES-1:0]          div_cnt;
    logic                        is_div, div_load, div_last;
    logic signed [DIFF_RES-1:0]  op_dx, op_dy;
    logic [DIFF_RES-1:0]         dx_mag;
    logic [SLOPE_RES-1:0]        div_quo, quo_nxt;
    logic [DIFF_RES-1:0]         div_rem, div_den;
    logic [DIFF_RES:0]           rem_shift;
    logic                        trial_ok, div_neg, div_zero;
    logic signed [SLOPE_RES-1:0] quotient;
    logic signed [SLOPE_RES-1:0] slope_long, slope_tm, slope_mb, x_split;
    logic signed [SLOPE_RES-1:0] fx_mid;
    logic                        mid_left;

    function automatic logic signed [SLOPE_RES-1:0] to_fixed(input logic signed [COORD_RES-1:0] c);
        return SLOPE_RES'(c) <<< FRACT_RES;
    endfunction

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = SORT;
            SORT:     state_nxt = DIV_LONG;
            DIV_LONG: if (div_last) state_nxt = DIV_TM;
            DIV_TM:   if (div_last) state_nxt = DIV_MB;
            DIV_MB:   if (div_last) state_nxt = SPLIT;
            SPLIT:    state_nxt = ORDER;
            ORDER:    state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE) && (state != DONE);
        done = (state == DONE);
    end

    assign is_div   = (state == DIV_LONG) || (state == DIV_TM) || (state == DIV_MB);
    assign div_load = is_div && (div_cnt == CNT_LOAD);
    assign div_last = is_div && (div_cnt == '0);

    // Each division: one load cycle at CNT_LOAD, then SLOPE_RES iterations down to 0.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n)                   div_cnt <= CNT_LOAD;
        else if (is_div && !div_last) div_cnt <= div_cnt - CNT_RES'(1);
        else                          div_cnt <= CNT_LOAD;
    end

    // Stable rank: an earlier vertex wins ties, so it needs only <= against later ones.
    always_comb begin
        rank[0] = {1'b0, vy[1] <  vy[0]} + {1'b0, vy[2] <  vy[0]};
        rank[1] = {1'b0, vy[0] <= vy[1]} + {1'b0, vy[2] <  vy[1]};
        rank[2] = {1'b0, vy[0] <= vy[2]} + {1'b0, vy[1] <= vy[2]};
    end

    always_comb begin
        op_dx = '0;
        op_dy = '0;
        case (state)
            DIV_LONG: begin
                op_dx = DIFF_RES'(x_bot) - DIFF_RES'(x_top);
                op_dy = DIFF_RES'(y_bot) - DIFF_RES'(y_top);
            end
            DIV_TM: begin
                op_dx = DIFF_RES'(x_mid) - DIFF_RES'(x_top);
                op_dy = DIFF_RES'(y_mid) - DIFF_RES'(y_top);
            end
            DIV_MB: begin
                op_dx = DIFF_RES'(x_bot) - DIFF_RES'(x_mid);
                op_dy = DIFF_RES'(y_bot) - DIFF_RES'(y_mid);
            end
            default: ;
        endcase
        dx_mag = op_dx[DIFF_RES-1] ? DIFF_RES'(-op_dx) : DIFF_RES'(op_dx);
    end

    // Restoring step on magnitudes; dy is non-negative after the sort.
    always_comb begin
        rem_shift = {div_rem, div_quo[SLOPE_RES-1]};
        trial_ok  = rem_shift >= {1'b0, div_den};
        quo_nxt   = {div_quo[SLOPE_RES-2:0], trial_ok};
        if (div_zero)     quotient = '0;
        else if (div_neg) quotient = -$signed(quo_nxt);
        else              quotient = $signed(quo_nxt);
    end

    assign fx_mid   = to_fixed(x_mid);
    assign mid_left = fx_mid <= x_split;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                vx[i] <= '0;
                vy[i] <= '0;
            end
            x_top <= '0; y_top <= '0; x_mid <= '0; y_mid <= '0; x_bot <= '0; y_bot <= '0;
            div_quo <= '0; div_rem <= '0; div_den <= '0; div_neg <= 1'b0; div_zero <= 1'b0;
            slope_long <= '0; slope_tm <= '0; slope_mb <= '0; x_split <= '0;
            b_x_p1 <= '0; b_y_p1 <= '0; b_x_p2 <= '0; b_y_p2 <= '0; b_x_p3 <= '0; b_y_p3 <= '0;
            b_dx_p1p2 <= '0; b_dx_p1p3 <= '0;
            t_x_p1 <= '0; t_y_p1 <= '0; t_x_p2 <= '0; t_y_p2 <= '0; t_x_p3 <= '0; t_y_p3 <= '0;
            t_dx_p1p2 <= '0; t_dx_p1p3 <= '0;
        end else begin
            if (state == IDLE && start) begin
                vx[0] <= x_v0; vy[0] <= y_v0;
                vx[1] <= x_v1; vy[1] <= y_v1;
                vx[2] <= x_v2; vy[2] <= y_v2;
            end
            if (state == SORT) begin
                for (int i = 0; i < 3; i++) begin
                    if (rank[i] == 2'd0) begin x_top <= vx[i]; y_top <= vy[i]; end
                    if (rank[i] == 2'd1) begin x_mid <= vx[i]; y_mid <= vy[i]; end
                    if (rank[i] == 2'd2) begin x_bot <= vx[i]; y_bot <= vy[i]; end
                end
            end
            if (div_load) begin
                div_quo  <= SLOPE_RES'(dx_mag) << FRACT_RES;
                div_rem  <= '0;
                div_den  <= op_dy;
                div_neg  <= op_dx[DIFF_RES-1];
                div_zero <= (op_dy == '0);
            end else if (is_div) begin
                div_quo <= quo_nxt;
                div_rem <= trial_ok ? DIFF_RES'(rem_shift - {1'b0, div_den}) : rem_shift[DIFF_RES-1:0];
            end
            if (div_last) begin
                case (state)
                    DIV_LONG: slope_long <= quotient;
                    DIV_TM:   slope_tm   <= quotient;
                    default:  slope_mb   <= quotient;
                endcase
            end
            if (state == SPLIT)
                x_split <= to_fixed(x_top) + slope_long * (SLOPE_RES'(y_mid) - SLOPE_RES'(y_top));
            if (state == ORDER) begin
                b_x_p1 <= to_fixed(x_top);
                b_y_p1 <= to_fixed(y_top);
                t_x_p1 <= to_fixed(x_bot);
                t_y_p1 <= to_fixed(y_bot);
                b_y_p2 <= to_fixed(y_mid);
                b_y_p3 <= to_fixed(y_mid);
                t_y_p2 <= to_fixed(y_mid);
                t_y_p3 <= to_fixed(y_mid);
                if (mid_left) begin
                    b_x_p2 <= fx_mid;     b_x_p3 <= x_split;
                    t_x_p2 <= fx_mid;     t_x_p3 <= x_split;
                    b_dx_p1p2 <= slope_tm;   b_dx_p1p3 <= slope_long;
                    t_dx_p1p2 <= slope_mb;   t_dx_p1p3 <= slope_long;
                end else begin
                    b_x_p2 <= x_split;    b_x_p3 <= fx_mid;
                    t_x_p2 <= x_split;    t_x_p3 <= fx_mid;
                    b_dx_p1p2 <= slope_long; b_dx_p1p3 <= slope_tm;
                    t_dx_p1p2 <= slope_long; t_dx_p1p3 <= slope_mb;
                end
            end
        end
    end

endmodule
